umi_ram: RTL and testbench
==========================

# umi_ram

Single-port byte-addressable memory that acts as a UMI device endpoint. It accepts UMI read, write and posted-write requests on a request channel and returns read-data or write-acknowledge responses on a response channel. It is the memory target behind the UMI client queues in simulation, and it must be fully synthesizable.

## Interface
Parameters:
- DW, 256: data bus width in bits; multiple of 8.
- AW, 64: address width.
- CW, 32: command width.
- MEM_BYTES, 4096: storage size in bytes; power of two.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- udev_req_valid  input  1  request valid.
- udev_req_ready  output  1  request ready.
- udev_req_cmd  input  CW  request command.
- udev_req_dstaddr  input  AW  target byte address.
- udev_req_srcaddr  input  AW  requester return address.
- udev_req_data  input  DW  write data; byte i is data[8i+7:8i].
- udev_resp_valid  output  1  response valid.
- udev_resp_ready  input  1  response ready.
- udev_resp_cmd  output  CW  response command.
- udev_resp_dstaddr  output  AW  equals the request srcaddr.
- udev_resp_srcaddr  output  AW  equals the request dstaddr.
- udev_resp_data  output  DW  read data.

## Operation
- Command fields:
  - opcode = cmd[4:0].
  - size = cmd[7:5].
  - len = cmd[15:8].
  - Byte count N = (len+1)<<size, clamped to DW/8.
- Opcodes:
  - REQ_READ=0x01, REQ_WRITE=0x03, REQ_POSTED=0x05.
  - RESP_READ=0x02, RESP_WRITE=0x04.
- Address: byte i maps to memory location (dstaddr+i) mod MEM_BYTES. Accesses wrap around the top of memory.
- REQ_WRITE:
  - Writes bytes 0..N-1 of data; other bytes are untouched.
  - Response: opcode RESP_WRITE, data 0.
- REQ_POSTED: writes the same bytes as REQ_WRITE; no response.
- REQ_READ:
  - Response: opcode RESP_READ.
  - data bytes 0..N-1 are the memory contents; upper bytes are 0.
- Response cmd: the request cmd with cmd[4:0] replaced by the response opcode. All other bits (size, len, upper fields) are copied.
- Any other opcode: the request is consumed and dropped. No memory change, no response.
- Memory contents are not cleared by reset.

## Timing
- Output register: one-entry response register.
- Ready rule: udev_req_ready = !udev_resp_valid || udev_resp_ready. It is a combinational function of the register state and resp_ready only, and must not depend on req_valid.
- A request is accepted on a rising edge where valid && ready.
  - The memory write commits at that edge.
  - Read data is sampled at that edge.
- Response latency: udev_resp_valid rises on the edge that accepts the request, so the response is visible the following cycle (1-cycle latency).
- Full throughput: with resp_ready held high, one request is accepted per cycle.
- Back-pressure: while resp_valid && !resp_ready, all udev_resp_* outputs hold stable and req_ready is 0.
- Ordering: a read accepted on the cycle after a write to the same address returns the new data. Responses leave in request order.
- Simultaneous events: when the response handshake and a new request accept happen on the same edge, the register is reloaded with the new response. Valid stays 1 and there is no bubble.
- Reset:
  - resp_valid=0; resp_cmd, resp_dstaddr, resp_srcaddr and resp_data = 0.
  - A pending response is discarded.
  - A request presented during reset is not accepted.

## Structure
- Shared package umi_ram_pkg holds:
  - the opcode constants;
  - the field position constants for opcode, size and len;
  - a function computing N.
- Optional sub-module umi_ram_mem: the byte array with a N-byte wrapping read/write port.
- Top level: decode, response register and handshake.

## Test plan
- Write then read:
  - REQ_WRITE dst=0x10, size=0, len=3, data=0xDEADBEEF, src=0x1234 -> RESP_WRITE with dstaddr=0x1234, srcaddr=0x10.
  - Then REQ_READ dst=0x10, len=3 -> RESP_READ with data=0xDEADBEEF and upper bytes 0.
- Posted write:
  - REQ_POSTED dst=0x20, 1 byte 0xA5 -> no response.
  - Then a 1-byte read of 0x20 -> 0xA5.
- Partial write: write 4 bytes 0x11223344 at 0x40, then 1 byte 0xFF at 0x41 -> 4-byte read returns 0x1122FF44.
- Wrap-around: 2-byte write 0xBBAA at MEM_BYTES-1 -> 1-byte reads return 0xAA at MEM_BYTES-1 and 0xBB at 0.
- Back-pressure:
  - Hold resp_ready=0 for 5 cycles after a read -> req_ready=0 and resp outputs stable.
  - Release -> exactly one response; a back-to-back stream of 8 reads then completes in 8 cycles.
- Reset mid-operation: assert rst while resp_valid=1 -> resp_valid=0 next cycle and no stale response afterwards. A bad opcode 0x1F produces no response.

Source files
------------

// File: rtl/umi_ram_pkg.sv
// umi_ram_pkg: UMI opcodes, command field positions and byte-count helper
package umi_ram_pkg;
  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;
  localparam int OP_LSB   = 0;
  localparam int OP_W     = 5;
  localparam int SIZE_LSB = 5;
  localparam int SIZE_W   = 3;
  localparam int LEN_LSB  = 8;
  localparam int LEN_W    = 8;
  function automatic int unsigned umi_bytes(input logic [2:0] size, input logic [7:0] len,
                                            input int unsigned max_bytes);
    int unsigned n;
    n = (32'(len) + 32'd1) << size;
    return n > max_bytes ? max_bytes : n;
  endfunction
endpackage

// File: rtl/umi_ram_mem.sv
// umi_ram_mem: byte array with an N-byte wrapping write port and combinational read port
//   clk; we_i commits wdata_i bytes 0..n_i-1 at addr_i+i (mod MEM_BYTES);
//   rdata_o returns bytes 0..n_i-1 from addr_i+i, upper bytes zero.
module umi_ram_mem #(
  parameter int DW        = 256,
  parameter int AW        = 64,
  parameter int MEM_BYTES = 4096,
  parameter int NW        = $clog2(DW / 8) + 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [NW-1:0] n_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  localparam int NB = DW / 8;
  localparam int IW = $clog2(MEM_BYTES);
  logic [7:0] mem_q [MEM_BYTES];
  logic [IW-1:0] base;
  assign base = addr_i[IW-1:0];
  always_ff @(posedge clk)
    if (we_i)
      for (int i = 0; i < NB; i++)
        if (NW'(i) < n_i) mem_q[base + IW'(i)] <= wdata_i[8*i +: 8];
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NB; i++)
      if (NW'(i) < n_i) rdata_o[8*i +: 8] = mem_q[base + IW'(i)];
  end
endmodule

// File: rtl/umi_ram.sv
// umi_ram: UMI device endpoint memory; decodes requests, one-entry response register
//   udev_req_*: request channel (valid/ready/cmd/dstaddr/srcaddr/data)
//   udev_resp_*: response channel, addresses swapped relative to the request
module umi_ram
  import umi_ram_pkg::*;
#(
  parameter int DW        = 256,
  parameter int AW        = 64,
  parameter int CW        = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          udev_req_valid,
  output logic          udev_req_ready,
  input  logic [CW-1:0] udev_req_cmd,
  input  logic [AW-1:0] udev_req_dstaddr,
  input  logic [AW-1:0] udev_req_srcaddr,
  input  logic [DW-1:0] udev_req_data,
  output logic          udev_resp_valid,
  input  logic          udev_resp_ready,
  output logic [CW-1:0] udev_resp_cmd,
  output logic [AW-1:0] udev_resp_dstaddr,
  output logic [AW-1:0] udev_resp_srcaddr,
  output logic [DW-1:0] udev_resp_data
);
  localparam int NB = DW / 8;
  localparam int NW = $clog2(NB) + 1;
  logic [OP_W-1:0] op;
  logic [NW-1:0] n;
  logic accept, we, is_read, load;
  logic [DW-1:0] rdata;
  logic resp_valid_q, resp_valid_d;
  logic [CW-1:0] resp_cmd_q, resp_cmd_d;
  logic [AW-1:0] resp_dst_q, resp_dst_d, resp_src_q, resp_src_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  assign op = udev_req_cmd[OP_LSB +: OP_W];
  assign n = NW'(umi_bytes(udev_req_cmd[SIZE_LSB +: SIZE_W], udev_req_cmd[LEN_LSB +: LEN_W], NB));
  assign udev_req_ready = !resp_valid_q || udev_resp_ready;
  // Requests presented while in reset are ignored entirely.
  assign accept = udev_req_valid && udev_req_ready && !rst;
  assign we = accept && (op == REQ_WRITE || op == REQ_POSTED);
  assign is_read = op == REQ_READ;
  assign load = accept && (is_read || op == REQ_WRITE);
  umi_ram_mem #(.DW(DW), .AW(AW), .MEM_BYTES(MEM_BYTES), .NW(NW)) u_mem (
    .clk(clk), .we_i(we), .addr_i(udev_req_dstaddr), .n_i(n),
    .wdata_i(udev_req_data), .rdata_o(rdata)
  );
  always_comb begin
    resp_valid_d = load ? 1'b1 : (udev_resp_ready ? 1'b0 : resp_valid_q);
    resp_cmd_d = load ? {udev_req_cmd[CW-1:OP_W], is_read ? RESP_READ : RESP_WRITE} : resp_cmd_q;
    resp_dst_d = load ? udev_req_srcaddr : resp_dst_q;
    resp_src_d = load ? udev_req_dstaddr : resp_src_q;
    resp_data_d = load ? (is_read ? rdata : '0) : resp_data_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_cmd_q <= '0;
      resp_dst_q <= '0;
      resp_src_q <= '0;
      resp_data_q <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_cmd_q <= resp_cmd_d;
      resp_dst_q <= resp_dst_d;
      resp_src_q <= resp_src_d;
      resp_data_q <= resp_data_d;
    end
  assign udev_resp_valid = resp_valid_q;
  assign udev_resp_cmd = resp_cmd_q;
  assign udev_resp_dstaddr = resp_dst_q;
  assign udev_resp_srcaddr = resp_src_q;
  assign udev_resp_data = resp_data_q;
endmodule

// File: tb/tb_umi_ram.sv
// tb_umi_ram: directed self-checking bench for umi_ram
module tb_umi_ram;
  localparam int DW = 256, AW = 64, CW = 32, MB = 4096;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, resp_valid, resp_ready = 1;
  logic [CW-1:0] req_cmd = '0, resp_cmd;
  logic [AW-1:0] req_dst = '0, req_src = '0, resp_dst, resp_src;
  logic [DW-1:0] req_data = '0, resp_data;
  int checks = 0, errors = 0;
  localparam logic [DW-1:0] PAT =
    256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100;
  logic [DW-1:0] cmd_hold, data_hold, dst_hold;
  umi_ram #(.DW(DW), .AW(AW), .CW(CW), .MEM_BYTES(MB)) dut (
    .clk(clk), .rst(rst),
    .udev_req_valid(req_valid), .udev_req_ready(req_ready), .udev_req_cmd(req_cmd),
    .udev_req_dstaddr(req_dst), .udev_req_srcaddr(req_src), .udev_req_data(req_data),
    .udev_resp_valid(resp_valid), .udev_resp_ready(resp_ready), .udev_resp_cmd(resp_cmd),
    .udev_resp_dstaddr(resp_dst), .udev_resp_srcaddr(resp_src), .udev_resp_data(resp_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [CW-1:0] c, input logic [AW-1:0] d, input logic [AW-1:0] s,
                      input logic [DW-1:0] w);
    req_valid = 1; req_cmd = c; req_dst = d; req_src = s; req_data = w;
    @(posedge clk); @(negedge clk);
    req_valid = 0;
  endtask
  task automatic idle;
    @(posedge clk); @(negedge clk);
  endtask
  initial begin
    @(negedge clk); idle();
    rst = 0;
    chk("rst_valid", DW'(resp_valid), 0);
    chk("rst_cmd", DW'(resp_cmd), 0);
    chk("rst_data", resp_data, 0);
    chk("rst_ready", DW'(req_ready), 1);
    send(32'h0303, 64'h10, 64'h1234, 256'hDEADBEEF);
    chk("wr_valid", DW'(resp_valid), 1);
    chk("wr_cmd", DW'(resp_cmd), 32'h0304);
    chk("wr_dst", DW'(resp_dst), 64'h1234);
    chk("wr_src", DW'(resp_src), 64'h10);
    chk("wr_data", resp_data, 0);
    send(32'h0301, 64'h10, 64'h55, '1);
    chk("rd_cmd", DW'(resp_cmd), 32'h0302);
    chk("rd_data", resp_data, 256'hDEADBEEF);
    send(32'h0005, 64'h20, 64'h1, 256'hA5);
    chk("posted_noresp", DW'(resp_valid), 0);
    send(32'h0001, 64'h20, 64'h2, '1);
    chk("posted_rd", resp_data, 256'hA5);
    send(32'h0303, 64'h40, 64'h3, 256'h11223344);
    send(32'h0003, 64'h41, 64'h3, 256'h99887766FF);
    send(32'h0301, 64'h40, 64'h3, '0);
    chk("partial_rd", resp_data, 256'h1122FF44);
    send(32'hABCD0041, 64'h40, 64'h4, '0);
    chk("size_rd", resp_data, 256'h1122FF44);
    chk("size_cmd", DW'(resp_cmd), 32'hABCD0042);
    send(32'h0103, MB - 1, 64'h5, 256'hBBAA);
    send(32'h0001, MB - 1, 64'h5, '0);
    chk("wrap_hi", resp_data, 256'hAA);
    send(32'h0001, 64'h0, 64'h5, '0);
    chk("wrap_lo", resp_data, 256'hBB);
    send(32'hFF03, 64'h100, 64'h6, PAT);
    send(32'hFF01, 64'h100, 64'h6, '0);
    chk("clamp_rd", resp_data, PAT);
    send(32'h0101, 64'h100, 64'h6, '0);
    chk("len1_rd", resp_data, 256'h0100);
    idle();
    chk("drained", DW'(resp_valid), 0);
    resp_ready = 0;
    send(32'h0301, 64'h10, 64'h77, '0);
    cmd_hold = DW'(resp_cmd); data_hold = resp_data; dst_hold = DW'(resp_dst);
    chk("bp_first", resp_data, 256'hDEADBEEF);
    req_valid = 1; req_cmd = 32'h0303; req_dst = 64'h10; req_data = 256'h0BADF00D;
    for (int k = 0; k < 5; k++) begin
      idle();
      chk("bp_ready", DW'(req_ready), 0);
      chk("bp_valid", DW'(resp_valid), 1);
      chk("bp_data", resp_data, data_hold);
      chk("bp_cmd", DW'(resp_cmd), cmd_hold);
      chk("bp_dst", DW'(resp_dst), dst_hold);
    end
    req_valid = 0; resp_ready = 1;
    idle();
    chk("bp_one_resp", DW'(resp_valid), 0);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        chk("stream_valid", DW'(resp_valid), 1);
        chk("stream_order", DW'(resp_dst), DW'(k - 1));
        chk("stream_data", resp_data, 256'hDEADBEEF);
      end
      req_valid = k < 8; req_cmd = 32'h0301; req_dst = 64'h10; req_src = AW'(k);
      if (k < 8) chk("stream_ready", DW'(req_ready), 1);
      idle();
    end
    chk("stream_done", DW'(resp_valid), 0);
    resp_ready = 0;
    send(32'h0301, 64'h10, 64'h88, '0);
    chk("rst_pre", DW'(resp_valid), 1);
    rst = 1; req_valid = 1; req_cmd = 32'h0303; req_dst = 64'h10; req_data = 256'h55;
    idle();
    chk("rst_mid_valid", DW'(resp_valid), 0);
    chk("rst_mid_data", resp_data, 0);
    chk("rst_mid_dst", DW'(resp_dst), 0);
    rst = 0; req_valid = 0; resp_ready = 1;
    idle(); idle();
    chk("rst_no_stale", DW'(resp_valid), 0);
    send(32'h031F, 64'h10, 64'h9, 256'h77);
    chk("bad_op_noresp", DW'(resp_valid), 0);
    send(32'h0301, 64'h10, 64'h9, '0);
    chk("after_rst_rd", resp_data, 256'hDEADBEEF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
